// File: rtl/scarv_cop_mem.sv
// COP load/store unit: one scalar load/store at a time over a req/gnt/recv
// memory port, with byte-lane placement into the COP GPR write port for loads.
module scarv_cop_mem (
  input  logic        g_clk,
  input  logic        g_resetn,
  output logic        g_clk_req,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [2:0]  id_op,
  input  logic [31:0] id_addr,
  input  logic [1:0]  id_lane,
  input  logic [3:0]  id_crd,
  input  logic [31:0] id_wdata,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_wen,
  output logic [3:0]  mem_ben,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_recv,
  input  logic [31:0] mem_rdata,
  input  logic        mem_error,
  output logic [3:0]  crd_wen,
  output logic [3:0]  crd_addr,
  output logic [31:0] crd_wdata,
  output logic        done_valid,
  output logic        done_error
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, WB} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state_q, state_d;
  logic        store_q, store_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  lane_q, lane_d;
  logic [3:0]  crd_q, crd_d;
  logic [31:0] swdata_q, swdata_d;
  logic [3:0]  sben_q, sben_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        misaligned;
  logic [7:0]  st_byte;
  logic [15:0] st_half;
  logic [31:0] st_wdata;
  logic [3:0]  st_ben;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_wdata;
  logic [3:0]  ld_wen;
  logic        crd_write;

  assign accept = id_valid & id_ready;

  // Alignment check on the incoming instruction; size 11 is always rejected.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    misaligned = 1'b1;
    case (id_op[1:0])
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = id_addr[0];
      SZ_WORD: misaligned = |id_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Store data is formatted once at accept so the bus fields are plain registers.
  always_comb begin
    st_byte  = id_wdata[{id_lane, 3'b000} +: 8];
    st_half  = id_wdata[{id_lane[0], 4'b0000} +: 16];
    st_wdata = id_wdata;
    st_ben   = 4'b1111;
    case (id_op[1:0])
      SZ_BYTE: begin
        st_wdata = {4{st_byte}};
        st_ben   = 4'b0001 << id_addr[1:0];
      end
      SZ_HALF: begin
        st_wdata = {2{st_half}};
        st_ben   = id_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = id_wdata;
        st_ben   = 4'b1111;
      end
    endcase
  end

  // Load extraction from the returned word and placement into the GPR lane.
  always_comb begin
    ld_byte  = rdata_q[{addr_q[1:0], 3'b000} +: 8];
    ld_half  = rdata_q[{addr_q[1], 4'b0000} +: 16];
    ld_wdata = rdata_q;
    ld_wen   = 4'b1111;
    case (size_q)
      SZ_BYTE: begin
        ld_wdata = {24'h0, ld_byte} << {lane_q, 3'b000};
        ld_wen   = 4'b0001 << lane_q;
      end
      SZ_HALF: begin
        ld_wdata = lane_q[0] ? {ld_half, 16'h0} : {16'h0, ld_half};
        ld_wen   = lane_q[0] ? 4'b1100 : 4'b0011;
      end
      default: begin
        ld_wdata = rdata_q;
        ld_wen   = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    size_d   = size_q;
    addr_d   = addr_q;
    lane_d   = lane_q;
    crd_d    = crd_q;
    swdata_d = swdata_q;
    sben_d   = sben_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          store_d  = id_op[2];
          size_d   = id_op[1:0];
          addr_d   = id_addr;
          lane_d   = id_lane;
          crd_d    = id_crd;
          swdata_d = st_wdata;
          sben_d   = id_op[2] ? st_ben : 4'b0000;
          err_d    = misaligned;
          state_d  = misaligned ? WB : REQ;
        end
      end
      REQ: begin
        if (mem_gnt) state_d = RSP;
      end
      RSP: begin
        if (mem_recv) begin
          rdata_d = mem_rdata;
          err_d   = mem_error;
          state_d = WB;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!g_resetn) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // NOTE: datapath registers carry no reset; every output they feed is gated
  // by the FSM state, which alone returns the unit to a clean idle.
  always_ff @(posedge g_clk) begin
    store_q  <= store_d;
    size_q   <= size_d;
    addr_q   <= addr_d;
    lane_q   <= lane_d;
    crd_q    <= crd_d;
    swdata_q <= swdata_d;
    sben_q   <= sben_d;
    rdata_q  <= rdata_d;
    err_q    <= err_d;
  end

  assign id_ready   = (state_q == IDLE);
  assign g_clk_req  = (state_q != IDLE) | id_valid;

  assign mem_req    = (state_q == REQ);
  assign mem_wen    = mem_req & store_q;
  assign mem_ben    = mem_req ? sben_q : 4'b0000;
  assign mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata  = (mem_req & store_q) ? swdata_q : 32'h0;

  assign done_valid = (state_q == WB);
  assign done_error = done_valid & err_q;

  assign crd_write  = done_valid & ~store_q & ~err_q;
  assign crd_wen    = crd_write ? ld_wen   : 4'b0000;
  assign crd_addr   = crd_write ? crd_q    : 4'h0;
  assign crd_wdata  = crd_write ? ld_wdata : 32'h0;

  // Bus fields must not move while a request waits for its grant.
  property p_req_stable;
    @(posedge g_clk) disable iff (!g_resetn)
      (mem_req && !mem_gnt) |=> (mem_req && $stable(mem_addr) && $stable(mem_ben)
                                 && $stable(mem_wen) && $stable(mem_wdata));
  endproperty
  a_req_stable: assert property (p_req_stable);

  property p_recv_after_gnt;
    @(posedge g_clk) disable iff (!g_resetn)
      (mem_req && mem_gnt) |-> !mem_recv;
  endproperty
  a_recv_after_gnt: assert property (p_recv_after_gnt);

endmodule

// File: tb/tb_scarv_cop_mem.sv
// Self-checking bench for scarv_cop_mem: directed scenarios plus randomized
// loads/stores checked against a byte-array reference model.
module tb_scarv_cop_mem;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        g_clk_req;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [2:0]  id_op = '0;
  logic [31:0] id_addr = '0;
  logic [1:0]  id_lane = '0;
  logic [3:0]  id_crd = '0;
  logic [31:0] id_wdata = '0;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_wen;
  logic [3:0]  mem_ben;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_recv = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_error = 1'b0;
  logic [3:0]  crd_wen;
  logic [3:0]  crd_addr;
  logic [31:0] crd_wdata;
  logic        done_valid;
  logic        done_error;

  scarv_cop_mem dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(g_clk_req),
    .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op), .id_addr(id_addr),
    .id_lane(id_lane), .id_crd(id_crd), .id_wdata(id_wdata),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen), .mem_ben(mem_ben),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_recv(mem_recv),
    .mem_rdata(mem_rdata), .mem_error(mem_error),
    .crd_wen(crd_wen), .crd_addr(crd_addr), .crd_wdata(crd_wdata),
    .done_valid(done_valid), .done_error(done_error)
  );

  always #5 g_clk = ~g_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // What the bench observed over one instruction.
  typedef struct {
    int          done_cyc;
    logic        done_err;
    logic [3:0]  cwen;
    logic [3:0]  caddr;
    logic [31:0] cwdata;
    int          req_cycles;
    logic [31:0] maddr;
    logic        mwen;
    logic [3:0]  mben;
    logic [31:0] mwdata;
    bit          unstable;
    bit          stray;
    logic        ready0;
    logic        clk_req0;
    logic        post_ready;
    logic        post_done;
  } res_t;

  // What the reference model predicts.
  typedef struct {
    int          done_cyc;
    bit          err;
    bit          access;
    bit          wen;
    logic [3:0]  ben;
    logic [31:0] mwdata;
    logic [31:0] maddr;
    logic [3:0]  cwen;
    logic [31:0] cwdata;
  } exp_t;

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] addr,
                                 input logic [1:0] lane, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input logic err,
                                 input int gd, input int rd);
    exp_t e;
    logic [7:0] wb[4];
    logic [7:0] rb[4];
    int sz, b, nbytes, src, bad;
    sz = int'(op[1:0]);
    b  = int'(addr[1:0]);
    bad = (sz == 3) || (sz == 1 && addr[0]) || (sz == 2 && b != 0);
    nbytes = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    src = (sz == 0) ? int'(lane) : (sz == 1) ? 2 * int'(lane[0]) : 0;
    for (int i = 0; i < 4; i++) begin
      wb[i] = wdata[8*i +: 8];
      rb[i] = rdata[8*i +: 8];
    end
    e.access   = (bad == 0);
    e.err      = (bad != 0) || err;
    e.done_cyc = (bad != 0) ? 1 : 2 + gd + rd;
    e.maddr    = addr & 32'hFFFF_FFFC;
    e.wen      = op[2];
    e.ben      = '0;
    e.mwdata   = '0;
    e.cwen     = '0;
    e.cwdata   = '0;
    if (op[2]) begin
      for (int k = 0; k < nbytes; k++) e.ben[b + k] = 1'b1;
      for (int i = 0; i < 4; i++) e.mwdata[8*i +: 8] = wb[src + (i % nbytes)];
    end else if (!e.err) begin
      for (int k = 0; k < nbytes; k++) begin
        e.cwen[src + k]           = 1'b1;
        e.cwdata[8*(src + k) +: 8] = rb[b + k];
      end
    end
    return e;
  endfunction

  // Issues one instruction at a negedge, plays memory, returns at the negedge
  // of the cycle after done.
  task automatic run_op(input logic [2:0] op, input logic [31:0] addr,
                        input logic [1:0] lane, input logic [3:0] crd,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input logic err, input int gd, input int rd,
                        output res_t r);
    int gnt_cyc;
    int cyc;
    r = '{default: 0};
    r.done_cyc = -1;
    id_valid = 1'b1; id_op = op; id_addr = addr; id_lane = lane;
    id_crd = crd; id_wdata = wdata;
    #1;
    r.ready0   = id_ready;
    r.clk_req0 = g_clk_req;
    @(negedge g_clk);
    id_valid = 1'b0;
    id_op = 3'($urandom_range(0, 7)); id_addr = $urandom;
    id_lane = 2'($urandom_range(0, 3)); id_crd = 4'($urandom_range(0, 15));
    id_wdata = $urandom;
    gnt_cyc = -1;
    cyc = 1;
    while (r.done_cyc < 0 && cyc <= 60) begin
      if (done_valid) begin
        r.done_cyc = cyc;
        r.done_err = done_error;
        r.cwen     = crd_wen;
        r.caddr    = crd_addr;
        r.cwdata   = crd_wdata;
      end else if (crd_wen != 4'b0000) begin
        r.stray = 1'b1;
      end
      if (mem_req) begin
        if (r.req_cycles == 0) begin
          r.maddr = mem_addr; r.mwen = mem_wen; r.mben = mem_ben; r.mwdata = mem_wdata;
        end else if (mem_addr !== r.maddr || mem_wen !== r.mwen ||
                     mem_ben !== r.mben || mem_wdata !== r.mwdata) begin
          r.unstable = 1'b1;
        end
        mem_gnt = (r.req_cycles == gd);
        if (mem_gnt) gnt_cyc = cyc;
        r.req_cycles++;
      end else begin
        mem_gnt = 1'b0;
      end
      if (gnt_cyc >= 0 && cyc == gnt_cyc + rd) begin
        mem_recv = 1'b1; mem_rdata = rdata; mem_error = err;
      end else begin
        mem_recv = 1'b0; mem_rdata = $urandom; mem_error = 1'($urandom_range(0, 1));
      end
      @(negedge g_clk);
      cyc++;
    end
    mem_gnt = 1'b0; mem_recv = 1'b0; mem_error = 1'b0;
    r.post_ready = id_ready;
    r.post_done  = done_valid;
  endtask

  task automatic test_reset();
    g_resetn = 1'b0;
    repeat (3) @(negedge g_clk);
    n_checks++;
    if (id_ready !== 1'b1) $display("FAIL reset_id_ready: got %b expected 1", id_ready);
    else n_pass++;
    n_checks++;
    if ({g_clk_req, mem_req, mem_wen, mem_ben, mem_addr, mem_wdata, crd_wen, crd_addr,
         crd_wdata, done_valid, done_error} !== '0)
      $display("FAIL reset_outputs_zero: got req=%b ben=%h addr=%h crd_wen=%h done=%b expected all 0",
               mem_req, mem_ben, mem_addr, crd_wen, done_valid);
    else n_pass++;
    g_resetn = 1'b1;
    @(negedge g_clk);
  endtask

  task automatic test_load_byte();
    res_t r;
    run_op(3'b000, 32'h0000_1003, 2'd2, 4'd5, 32'h0, 32'hAABB_CCDD, 1'b0, 0, 1, r);
    n_checks++;
    if (r.ready0 !== 1'b1 || r.clk_req0 !== 1'b1)
      $display("FAIL lb_accept: got ready=%b clk_req=%b expected 1/1", r.ready0, r.clk_req0);
    else n_pass++;
    n_checks++;
    if (r.maddr !== 32'h0000_1000 || r.mben !== 4'h0 || r.mwen !== 1'b0 || r.req_cycles !== 1)
      $display("FAIL lb_bus: got addr=%h ben=%h wen=%b reqs=%0d expected 00001000/0/0/1",
               r.maddr, r.mben, r.mwen, r.req_cycles);
    else n_pass++;
    n_checks++;
    if (r.done_cyc !== 3 || r.done_err !== 1'b0)
      $display("FAIL lb_done: got cyc=%0d err=%b expected 3/0", r.done_cyc, r.done_err);
    else n_pass++;
    n_checks++;
    if (r.cwen !== 4'b0100 || r.cwdata !== 32'h00AA_0000 || r.caddr !== 4'd5)
      $display("FAIL lb_crd: got wen=%b data=%h addr=%0d expected 0100/00aa0000/5",
               r.cwen, r.cwdata, r.caddr);
    else n_pass++;
  endtask

  task automatic test_store_half();
    res_t r;
    run_op(3'b101, 32'h0000_2002, 2'd1, 4'd9, 32'h1234_5678, 32'h0, 1'b0, 0, 1, r);
    n_checks++;
    if (r.mben !== 4'b1100 || r.mwdata !== 32'h1234_1234 || r.mwen !== 1'b1 ||
        r.maddr !== 32'h0000_2000)
      $display("FAIL sh_bus: got ben=%b data=%h wen=%b addr=%h expected 1100/12341234/1/00002000",
               r.mben, r.mwdata, r.mwen, r.maddr);
    else n_pass++;
    n_checks++;
    if (r.done_cyc !== 3 || r.done_err !== 1'b0 || r.cwen !== 4'b0000 || r.stray)
      $display("FAIL sh_done: got cyc=%0d err=%b crd_wen=%b expected 3/0/0000",
               r.done_cyc, r.done_err, r.cwen);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    res_t r;
    run_op(3'b010, 32'h0000_3001, 2'd0, 4'd4, 32'h0, 32'hFFFF_FFFF, 1'b0, 0, 1, r);
    n_checks++;
    if (r.req_cycles !== 0 || r.done_cyc !== 1 || r.done_err !== 1'b1 || r.cwen !== 4'b0000)
      $display("FAIL lw_misaligned: got reqs=%0d cyc=%0d err=%b crd_wen=%b expected 0/1/1/0000",
               r.req_cycles, r.done_cyc, r.done_err, r.cwen);
    else n_pass++;
    n_checks++;
    if (r.post_ready !== 1'b1 || r.post_done !== 1'b0)
      $display("FAIL misaligned_return_idle: got ready=%b done=%b expected 1/0",
               r.post_ready, r.post_done);
    else n_pass++;
  endtask

  task automatic test_gnt_stall_error();
    res_t r;
    run_op(3'b010, 32'h0000_4000, 2'd0, 4'd6, 32'h0, 32'h1111_2222, 1'b1, 3, 1, r);
    n_checks++;
    if (r.req_cycles !== 4 || r.unstable || r.maddr !== 32'h0000_4000)
      $display("FAIL stall_req: got reqs=%0d unstable=%b addr=%h expected 4/0/00004000",
               r.req_cycles, r.unstable, r.maddr);
    else n_pass++;
    n_checks++;
    if (r.done_cyc !== 6 || r.done_err !== 1'b1 || r.cwen !== 4'b0000)
      $display("FAIL stall_bus_error: got cyc=%0d err=%b crd_wen=%b expected 6/1/0000",
               r.done_cyc, r.done_err, r.cwen);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    bit bad_done;
    bit bad_crd;
    bit bad_idle;
    id_valid = 1'b1; id_op = 3'b010; id_addr = 32'h0000_5000; id_crd = 4'd7;
    @(negedge g_clk);
    id_valid = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1) $display("FAIL rst_mid_req: got %b expected 1", mem_req);
    else n_pass++;
    mem_gnt = 1'b1;
    @(negedge g_clk);
    mem_gnt = 1'b0;
    g_resetn = 1'b0;
    @(negedge g_clk);
    g_resetn = 1'b1;
    @(negedge g_clk);
    mem_recv = 1'b1; mem_rdata = 32'hDEAD_BEEF; mem_error = 1'b0;
    bad_done = 0; bad_crd = 0; bad_idle = 0;
    for (int i = 0; i < 4; i++) begin
      if (done_valid !== 1'b0) bad_done = 1;
      if (crd_wen !== 4'b0000) bad_crd = 1;
      if (id_ready !== 1'b1 || mem_req !== 1'b0) bad_idle = 1;
      @(negedge g_clk);
      mem_recv = 1'b0;
    end
    n_checks++;
    if (bad_done) $display("FAIL rst_mid_done: got a done pulse expected none");
    else n_pass++;
    n_checks++;
    if (bad_crd) $display("FAIL rst_mid_crd: got a GPR write expected none");
    else n_pass++;
    n_checks++;
    if (bad_idle) $display("FAIL rst_mid_idle: got ready=%b req=%b expected 1/0", id_ready, mem_req);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    res_t r1;
    res_t r2;
    run_op(3'b001, 32'h0000_0010, 2'd0, 4'd3, 32'h0, 32'h8765_4321, 1'b0, 0, 1, r1);
    run_op(3'b001, 32'h0000_0012, 2'd1, 4'd3, 32'h0, 32'h8765_4321, 1'b0, 0, 1, r2);
    n_checks++;
    if (r1.cwen !== 4'b0011 || r1.cwdata !== 32'h0000_4321 || r1.caddr !== 4'd3)
      $display("FAIL b2b_first: got wen=%b data=%h addr=%0d expected 0011/00004321/3",
               r1.cwen, r1.cwdata, r1.caddr);
    else n_pass++;
    n_checks++;
    if (r2.ready0 !== 1'b1 || r2.done_cyc !== 3 || r2.cwen !== 4'b1100 ||
        r2.cwdata !== 32'h8765_0000 || r2.caddr !== 4'd3)
      $display("FAIL b2b_second: got ready=%b cyc=%0d wen=%b data=%h addr=%0d expected 1/3/1100/87650000/3",
               r2.ready0, r2.done_cyc, r2.cwen, r2.cwdata, r2.caddr);
    else n_pass++;
  endtask

  task automatic test_random();
    res_t r;
    exp_t e;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [1:0]  lane;
    logic [3:0]  crd;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int gd, rd;
    for (int n = 0; n < 40; n++) begin
      op    = 3'($urandom_range(0, 7));
      addr  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (op[1:0] == 2'b01) addr[0] = 1'b0;
        if (op[1:0] == 2'b10) addr[1:0] = 2'b00;
      end
      lane  = 2'($urandom_range(0, 3));
      crd   = 4'($urandom_range(0, 15));
      wdata = $urandom;
      rdata = $urandom;
      err   = ($urandom_range(0, 7) == 0);
      gd    = $urandom_range(0, 3);
      rd    = $urandom_range(1, 3);
      e = model(op, addr, lane, wdata, rdata, err, gd, rd);
      run_op(op, addr, lane, crd, wdata, rdata, err, gd, rd, r);
      n_checks++;
      if (r.done_cyc !== e.done_cyc || r.done_err !== e.err)
        $display("FAIL rnd%0d_done: got cyc=%0d err=%b expected %0d/%b (op=%b addr=%h)",
                 n, r.done_cyc, r.done_err, e.done_cyc, e.err, op, addr);
      else n_pass++;
      n_checks++;
      if (r.cwen !== e.cwen || (e.cwen != 4'b0000 && (r.cwdata !== e.cwdata || r.caddr !== crd)))
        $display("FAIL rnd%0d_crd: got wen=%b data=%h addr=%0d expected %b/%h/%0d (op=%b addr=%h lane=%0d)",
                 n, r.cwen, r.cwdata, r.caddr, e.cwen, e.cwdata, crd, op, addr, lane);
      else n_pass++;
      n_checks++;
      if (r.req_cycles !== (e.access ? gd + 1 : 0) || r.unstable || r.stray)
        $display("FAIL rnd%0d_handshake: got reqs=%0d unstable=%b stray=%b expected %0d/0/0",
                 n, r.req_cycles, r.unstable, r.stray, e.access ? gd + 1 : 0);
      else n_pass++;
      if (e.access) begin
        n_checks++;
        if (r.maddr !== e.maddr || r.mwen !== e.wen || r.mben !== e.ben ||
            (e.wen && r.mwdata !== e.mwdata))
          $display("FAIL rnd%0d_bus: got addr=%h wen=%b ben=%b data=%h expected %h/%b/%b/%h",
                   n, r.maddr, r.mwen, r.mben, r.mwdata, e.maddr, e.wen, e.ben, e.mwdata);
        else n_pass++;
      end
    end
  endtask

  initial begin
    @(negedge g_clk);
    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_gnt_stall_error();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
